// File: rtl/mem_write_seq_pkg.sv
// Shared constants and state encoding for the register-file write sequencer.
package mem_write_seq_pkg;
    localparam int DW        = 6;
    localparam int AW        = 2;
    localparam int MEM_DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        VERIFY = 2'd2
    } state_t;
endpackage

// File: rtl/mem_write_seq_sync_fifo2.sv
// Two-entry first-in first-out buffer with a combinational head output.
module sync_fifo2 #(
    parameter int DW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_din,
    input  logic          i_pop,
    output logic          o_full,
    output logic          o_empty,
    output logic [DW-1:0] o_head
);
    logic [DW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;
    logic          w_push;
    logic          w_pop;

    // Guard against overflow/underflow regardless of what the caller does.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/mem_write_seq.sv
// Write sequencer for the 4x6 register file: buffers words, writes them to
// sequential addresses, reads each back and flags the first mismatch.
//
// state  | meaning
// IDLE   | nothing buffered, memory untouched
// WRITE  | one cycle with ld high, head popped into the compare register
// VERIFY | ld low, address held; compare readback on the last cycle
module mem_write_seq #(
    parameter int DW         = mem_write_seq_pkg::DW,
    parameter int AW         = mem_write_seq_pkg::AW,
    parameter int VERIFY_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          clr_err,
    output logic [AW-1:0] mem_sel,
    output logic [DW-1:0] mem_din,
    output logic          mem_ld,
    input  logic [DW-1:0] mem_dout,
    output logic          frame_done,
    output logic          err,
    output logic [AW-1:0] err_addr
);
    import mem_write_seq_pkg::*;

    localparam logic [1:0]    VCNT_LOAD = 2'(VERIFY_LAT - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_exp_data;
    logic [DW-1:0] r_mem_din;
    logic          r_mem_ld;
    logic          r_frame_done;
    logic          r_err;
    logic [AW-1:0] r_err_addr;
    logic [1:0]    r_vcnt;

    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [DW-1:0] w_fifo_head;
    logic          w_push;
    logic          w_pop;
    logic          w_vdone;
    logic          w_mismatch;
    logic          w_ld_nxt;

    assign in_ready = !w_fifo_full && !rst;
    assign w_push   = in_valid && in_ready;

    sync_fifo2 #(.DW(DW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (in_data),
        .i_pop   (w_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_fifo_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!w_fifo_empty) w_state_nxt = WRITE;
            WRITE:   w_state_nxt = VERIFY;
            VERIFY:  if (w_vdone) w_state_nxt = w_fifo_empty ? IDLE : WRITE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_pop      = (r_state == WRITE);
        w_vdone    = (r_state == VERIFY) && (r_vcnt == 2'd0);
        w_mismatch = w_vdone && (mem_dout != r_exp_data);
        w_ld_nxt   = (w_state_nxt == WRITE);
    end

    // Outputs are registered from the next state so ld lines up with WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_exp_data   <= '0;
            r_mem_din    <= '0;
            r_mem_ld     <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
            r_err_addr   <= '0;
            r_vcnt       <= 2'd0;
        end else begin
            r_mem_ld     <= w_ld_nxt;
            r_frame_done <= w_vdone && (r_addr == LAST_ADDR);
            if (w_ld_nxt) begin
                r_mem_din <= w_fifo_head;
            end
            if (w_pop) begin
                r_exp_data <= w_fifo_head;
            end
            if (r_state == WRITE) begin
                r_vcnt <= VCNT_LOAD;
            end else if ((r_state == VERIFY) && (r_vcnt != 2'd0)) begin
                r_vcnt <= r_vcnt - 2'd1;
            end
            if (w_vdone) begin
                r_addr <= r_addr + AW'(1);
            end
            // A mismatch beats a same-cycle clear and records its address.
            if (w_mismatch && (!r_err || clr_err)) begin
                r_err      <= 1'b1;
                r_err_addr <= r_addr;
            end else if (clr_err) begin
                r_err      <= 1'b0;
                r_err_addr <= '0;
            end
        end
    end

    assign mem_sel    = r_addr;
    assign mem_din    = r_mem_din;
    assign mem_ld     = r_mem_ld;
    assign frame_done = r_frame_done;
    assign err        = r_err;
    assign err_addr   = r_err_addr;
endmodule

// File: tb/tb_mem_write_seq.sv
// Randomised scoreboard bench for mem_write_seq with a behavioural memory.
module tb_mem_write_seq;
    localparam int VL = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [5:0] in_data = '0;
    logic       in_ready;
    logic       clr_err = 1'b0;
    logic [1:0] mem_sel;
    logic [5:0] mem_din;
    logic       mem_ld;
    logic [5:0] mem_dout;
    logic       frame_done;
    logic       err;
    logic [1:0] err_addr;

    mem_write_seq #(.VERIFY_LAT(VL)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .clr_err    (clr_err),
        .mem_sel    (mem_sel),
        .mem_din    (mem_din),
        .mem_ld     (mem_ld),
        .mem_dout   (mem_dout),
        .frame_done (frame_done),
        .err        (err),
        .err_addr   (err_addr)
    );

    always #5 clk = ~clk;

    // Register-file model with an optional stuck-at-zero read port address.
    logic [5:0] mem_model [4];
    logic       bad_en = 1'b0;
    logic [1:0] bad_addr = 2'd0;
    always @(posedge clk) if (mem_ld) mem_model[mem_sel] <= mem_din;
    assign mem_dout = (bad_en && mem_sel == bad_addr) ? 6'd0 : mem_model[mem_sel];

    typedef struct {int addr; int data;} wr_t;
    wr_t exp_q[$];
    int  wr_cyc[$];
    int  checks = 0, errors = 0;
    int  m_addr = 0, m_err_addr = 0;
    bit  m_err = 0;
    int  exp_frames = 0, obs_frames = 0, acc_cnt = 0, obs_writes = 0;
    int  cyc = 0, stalls = 0;
    bit  prev_ld = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Each accepted word goes to the next address; readback of a stuck
    // address returns 0, so a nonzero word there is the first error if none yet.
    function automatic void model_accept(input int d);
        wr_t w;
        w.addr = m_addr;
        w.data = d;
        exp_q.push_back(w);
        acc_cnt++;
        if (bad_en && m_addr == int'(bad_addr) && d != 0 && !m_err) begin
            m_err      = 1;
            m_err_addr = m_addr;
        end
        if (m_addr == 3) exp_frames++;
        m_addr = (m_addr + 1) % 4;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_addr = 0; m_err = 0; m_err_addr = 0;
        exp_frames = 0; obs_frames = 0;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_ld = 0;
        end else begin
            if (frame_done) obs_frames++;
            if (mem_ld) begin
                wr_t w;
                obs_writes++;
                wr_cyc.push_back(cyc);
                chk("ld_width", int'(prev_ld), 0);
                chk("write_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    chk("wr_addr", int'(mem_sel), w.addr);
                    chk("wr_data", int'(mem_din), w.data);
                end
            end
            prev_ld = mem_ld;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int d);
        bit rdy;
        bit done = 0;
        int t = 0;
        in_valid = 1'b1;
        in_data  = 6'(d);
        while (!done && t < 200) begin
            rdy = in_ready;
            if (!rdy) stalls++;
            @(posedge clk);
            if (rdy) begin
                model_accept(d);
                done = 1;
            end
            @(negedge clk);
            t++;
        end
        in_valid = 1'b0;
        if (!done) chk("handshake_timeout", int'(done), 1);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (VL + 3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_err = 0;
        m_err_addr = 0;
        chk("clr_err", int'(err), 0);
        chk("clr_err_addr", int'(err_addr), 0);
    endtask

    initial begin
        int a0, w0, t;
        for (int i = 0; i < 4; i++) mem_model[i] = '0;

        repeat (3) @(negedge clk);
        chk("rst_mem_ld", int'(mem_ld), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_mem_sel", int'(mem_sel), 0);
        chk("rst_mem_din", int'(mem_din), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_err_addr", int'(err_addr), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(in_ready), 1);

        // Single word: ld appears in the cycle after the edge following accept.
        in_valid = 1'b1;
        in_data  = 6'd3;
        @(posedge clk);
        model_accept(3);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_cycle0_ld", int'(mem_ld), 0);
        @(negedge clk);
        chk("lat_cycle1_ld", int'(mem_ld), 1);
        chk("single_sel", int'(mem_sel), 0);
        chk("single_din", int'(mem_din), 3);
        @(negedge clk);
        chk("single_ld_drop", int'(mem_ld), 0);
        drain();
        chk("single_err", int'(err), 0);

        // Full frame streamed back-to-back.
        do_reset();
        wr_cyc.delete();
        stalls = 0;
        send(3); send(4); send(5); send(6);
        drain();
        chk("frame_writes", wr_cyc.size(), 4);
        for (int i = 1; i < wr_cyc.size(); i++)
            chk("write_spacing", wr_cyc[i] - wr_cyc[i-1], 1 + VL);
        chk("ready_dropped", int'(stalls > 0), 1);
        chk("frame_done_cnt", obs_frames, exp_frames);

        // Wrap into the next frame.
        send(5); send(2);
        drain();
        chk("wrap_frame_cnt", obs_frames, exp_frames);

        // Readback mismatches; first address sticks.
        bad_en = 1'b1;
        bad_addr = 2'd2;
        send(5);
        drain();
        chk("mm_err", int'(err), int'(m_err));
        chk("mm_err_addr", int'(err_addr), m_err_addr);
        bad_addr = 2'd3;
        send(9);
        drain();
        chk("mm2_err", int'(err), int'(m_err));
        chk("mm2_err_addr", int'(err_addr), m_err_addr);

        // Clear coinciding with a mismatch at address 0: mismatch wins.
        bad_addr = 2'd0;
        send(6);
        t = 0;
        while (!mem_ld && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_err = 1;
        m_err_addr = 0;
        drain();
        chk("clr_vs_mm_err", int'(err), int'(m_err));
        chk("clr_vs_mm_addr", int'(err_addr), m_err_addr);
        bad_en = 1'b0;
        pulse_clear();

        // Backpressure: every accepted handshake produces exactly one write.
        a0 = acc_cnt;
        w0 = obs_writes;
        for (int i = 0; i < 6; i++) send(1);
        drain();
        chk("bp_accepts", acc_cnt - a0, 6);
        chk("bp_writes", obs_writes - w0, acc_cnt - a0);

        // Randomised phases with random gaps and stuck addresses.
        for (int ph = 0; ph < 3; ph++) begin
            bad_en   = 1'($urandom_range(0, 1));
            bad_addr = 2'($urandom_range(0, 3));
            for (int n = 0; n < 20; n++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send(int'($urandom_range(0, 63)));
            end
            drain();
            chk("rand_err", int'(err), int'(m_err));
            if (m_err) chk("rand_err_addr", int'(err_addr), m_err_addr);
            chk("rand_frames", obs_frames, exp_frames);
            bad_en = 1'b0;
            pulse_clear();
        end

        // Reset during VERIFY with one word buffered.
        send(10);
        send(11);
        chk("pre_rst_write", int'(mem_ld), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_ld", int'(mem_ld), 0);
        chk("rst_mid_ready", int'(in_ready), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        w0 = obs_writes;
        send(12);
        drain();
        chk("post_rst_writes", obs_writes - w0, 1);

        // Reset while ld is high: ld must fall without a clock edge.
        send(20);
        t = 0;
        while (!mem_ld && t < 20) begin
            @(negedge clk);
            t++;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("async_ld_drop", int'(mem_ld), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst2_sel", int'(mem_sel), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule
